// File: rtl/xvga_pkg.sv
// Shared XVGA (1024x768) timing constants and small helpers used by the
// timing generator and by the sprite modules that align to it.
package xvga_pkg;

  // Default horizontal timing, in pixels
  localparam int XVGA_H_ACTIVE = 1024;
  localparam int XVGA_H_FP     = 24;
  localparam int XVGA_H_SYNC   = 136;
  localparam int XVGA_H_BP     = 160;
  localparam int XVGA_H_TOTAL  = XVGA_H_ACTIVE + XVGA_H_FP + XVGA_H_SYNC + XVGA_H_BP;

  // Default vertical timing, in lines
  localparam int XVGA_V_ACTIVE = 768;
  localparam int XVGA_V_FP     = 3;
  localparam int XVGA_V_SYNC   = 6;
  localparam int XVGA_V_BP     = 29;
  localparam int XVGA_V_TOTAL  = XVGA_V_ACTIVE + XVGA_V_FP + XVGA_V_SYNC + XVGA_V_BP;

  // The three video control bits that travel down the sprite pipeline
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } sync_bits_t;

  // Idle/reset value of the control bits: syncs inactive (high), blanked
  localparam logic [2:0] SYNC_IDLE = 3'b111;

  // True when val lies inside the inclusive window [lo, hi]
  function automatic logic in_window(input logic [15:0] val,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register for the hsync/vsync/blank bundle, used to line
// the control bits up with a pipelined pixel path. DEPTH=0 is a plain wire.
module sync_delay_line #(
  parameter int         WIDTH     = 3,
  parameter int         DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    // Clock and reset are not needed when there is nothing to store
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst_n;
    assign dout        = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Each stage takes the previous one; stage 0 takes the input
    always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // Shift register, all stages forced to the idle value on reset
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RESET_VAL;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/xvga_timing.sv
// XVGA raster timing generator: pixel/line counters with registered sync,
// blank and frame-start decodes, plus a delayed copy of the control bits.
// Optional frame counter enabled by defining XVGA_FRAME_COUNTER_EN.
module xvga_timing
  import xvga_pkg::*;
#(
  parameter int H_ACTIVE   = XVGA_H_ACTIVE,
  parameter int H_FP       = XVGA_H_FP,
  parameter int H_SYNC     = XVGA_H_SYNC,
  parameter int H_BP       = XVGA_H_BP,
  parameter int V_ACTIVE   = XVGA_V_ACTIVE,
  parameter int V_FP       = XVGA_V_FP,
  parameter int V_SYNC     = XVGA_V_SYNC,
  parameter int V_BP       = XVGA_V_BP,
  parameter int PIPE_DELAY = 3   // 0..7
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start,
  output logic        hsync_d,
  output logic        vsync_d,
  output logic        blank_d,
  output logic [7:0]  frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_BLANK  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_BLANK  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        bl_q, bl_d;
  logic        fs_q, fs_d;

  // Next raster position: pixel every clock, line on the pixel wrap
  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
    end
  end

  // Decodes are taken from the next position so they register alongside it
  always_comb begin
    hs_d = ~in_window(16'(hcount_d), 16'(HS_FIRST), 16'(HS_LAST));
    vs_d = ~in_window(16'(vcount_d), 16'(VS_FIRST), 16'(VS_LAST));
    bl_d = (hcount_d >= H_BLANK) || (vcount_d >= V_BLANK);
    fs_d = (hcount_d == '0) && (vcount_d == '0);
  end

  // Reset parks on the last pixel of the frame so the first edge starts at 0,0
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q <= H_LAST;
      vcount_q <= V_LAST;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      bl_q     <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      bl_q     <= bl_d;
      fs_q     <= fs_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign blank       = bl_q;
  assign frame_start = fs_q;

  sync_bits_t dly_in, dly_out;
  assign dly_in = '{hsync: hs_q, vsync: vs_q, blank: bl_q};

  sync_delay_line #(
    .WIDTH    (3),
    .DEPTH    (PIPE_DELAY),
    .RESET_VAL(SYNC_IDLE)
  ) u_sync_delay (
    .clk  (pixel_clk),
    .rst_n(reset_n),
    .din  (dly_in),
    .dout (dly_out)
  );

  assign hsync_d = dly_out.hsync;
  assign vsync_d = dly_out.vsync;
  assign blank_d = dly_out.blank;

`ifdef XVGA_FRAME_COUNTER_EN
  logic [7:0] fcnt_q, fcnt_d;

  // Count on the same edge that raises frame_start; wraps naturally at 255
  always_comb begin
    fcnt_d = fs_d ? fcnt_q + 8'd1 : fcnt_q;
  end

  // Frame counter register
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt_q <= 8'd0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign frame_count = fcnt_q;
`else
  assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_xvga_timing.sv
// Scoreboard bench for xvga_timing. Two instances share clock and reset:
// A uses the default XVGA timing with PIPE_DELAY=3, B uses a tiny raster with
// PIPE_DELAY=0 so that vertical windows and many frames fit in a short run.
// Expected outputs come from a position model: cycles since reset release.
module tb_xvga_timing;

  typedef struct {
    int ha, hfp, hs, hbp;
    int va, vfp, vs, vbp;
    int pd;
  } tcfg_t;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs, vs, bl, fs;
    logic        hsd, vsd, bld;
    logic [7:0]  fc;
  } obs_t;

  localparam tcfg_t CA = '{ha: 1024, hfp: 24, hs: 136, hbp: 160,
                           va: 768, vfp: 3, vs: 6, vbp: 29, pd: 3};
  localparam tcfg_t CB = '{ha: 6, hfp: 1, hs: 2, hbp: 1,
                           va: 4, vfp: 1, vs: 2, vbp: 1, pd: 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] a_h, b_h;
  logic [9:0]  a_v, b_v;
  logic a_hs, a_vs, a_bl, a_fs, a_hsd, a_vsd, a_bld;
  logic b_hs, b_vs, b_bl, b_fs, b_hsd, b_vsd, b_bld;
  logic [7:0] a_fc, b_fc;

  xvga_timing #(
    .H_ACTIVE(1024), .H_FP(24), .H_SYNC(136), .H_BP(160),
    .V_ACTIVE(768), .V_FP(3), .V_SYNC(6), .V_BP(29), .PIPE_DELAY(3)
  ) dut_a (
    .pixel_clk(clk), .reset_n(rst_n), .hcount(a_h), .vcount(a_v),
    .hsync(a_hs), .vsync(a_vs), .blank(a_bl), .frame_start(a_fs),
    .hsync_d(a_hsd), .vsync_d(a_vsd), .blank_d(a_bld), .frame_count(a_fc)
  );

  xvga_timing #(
    .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DELAY(0)
  ) dut_b (
    .pixel_clk(clk), .reset_n(rst_n), .hcount(b_h), .vcount(b_v),
    .hsync(b_hs), .vsync(b_vs), .blank(b_bl), .frame_start(b_fs),
    .hsync_d(b_hsd), .vsync_d(b_vsd), .blank_d(b_bld), .frame_count(b_fc)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int t_model = -1;
  obs_t qa[$];
  obs_t qb[$];

  // Raster state t cycles after reset release; t<0 means held in reset
  function automatic obs_t raster(tcfg_t c, int t);
    obs_t o;
    int ht, vt, h, v;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    o = '0;
    if (t < 0) begin
      o.h = 11'(ht - 1);
      o.v = 10'(vt - 1);
      o.hs = 1'b1; o.vs = 1'b1; o.bl = 1'b1; o.fs = 1'b0; o.fc = 8'd0;
    end else begin
      h = t % ht;
      v = (t / ht) % vt;
      o.h  = 11'(h);
      o.v  = 10'(v);
      o.hs = !(h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs);
      o.vs = !(v >= c.va + c.vfp && v < c.va + c.vfp + c.vs);
      o.bl = (h >= c.ha) || (v >= c.va);
      o.fs = (h == 0) && (v == 0);
`ifdef XVGA_FRAME_COUNTER_EN
      o.fc = 8'(((t / (ht * vt)) + 1) % 256);
`else
      o.fc = 8'd0;
`endif
    end
    return o;
  endfunction

  // Full expected output set, delayed bits looked up PIPE_DELAY cycles back
  function automatic obs_t model(tcfg_t c, int t);
    obs_t o, past;
    o    = raster(c, t);
    past = raster(c, (t < 0) ? -1 : t - c.pd);
    o.hsd = past.hs;
    o.vsd = past.vs;
    o.bld = past.bl;
    return o;
  endfunction

  task automatic compare(string name, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: actual h=%0d v=%0d hs=%b vs=%b bl=%b fs=%b hsd=%b vsd=%b bld=%b fc=%0d, required h=%0d v=%0d hs=%b vs=%b bl=%b fs=%b hsd=%b vsd=%b bld=%b fc=%0d",
               name, cycle, act.h, act.v, act.hs, act.vs, act.bl, act.fs, act.hsd, act.vsd, act.bld, act.fc,
               exp.h, exp.v, exp.hs, exp.vs, exp.bl, exp.fs, exp.hsd, exp.vsd, exp.bld, exp.fc);
    end
  endtask

  // Model: track position since release, push expectations mid-cycle
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) t_model++;
      else       t_model = -1;
      #4;
      qa.push_back(model(CA, rst_n ? t_model : -1));
      qb.push_back(model(CB, rst_n ? t_model : -1));
    end
  end

  // Monitor: every cycle both instances present a full output set
  initial begin
    obs_t act, exp;
    forever begin
      @(negedge clk);
      cycle++;
      act = '{h: a_h, v: a_v, hs: a_hs, vs: a_vs, bl: a_bl, fs: a_fs,
              hsd: a_hsd, vsd: a_vsd, bld: a_bld, fc: a_fc};
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut_a_queue cycle %0d: actual empty, required one entry", cycle);
      end else begin
        exp = qa.pop_front();
        compare("dut_a", act, exp);
      end
      act = '{h: b_h, v: b_v, hs: b_hs, vs: b_vs, bl: b_bl, fs: b_fs,
              hsd: b_hsd, vsd: b_vsd, bld: b_bld, fc: b_fc};
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut_b_queue cycle %0d: actual empty, required one entry", cycle);
      end else begin
        exp = qb.pop_front();
        compare("dut_b", act, exp);
      end
    end
  end

  // Stimulus: reset sequences; all other inputs are the free-running clock
  initial begin
    int run_len, hold_len;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b1;
    $display("txn: reset held 5 clocks, released");

    // Long run: A covers 15 lines, B covers more than 256 frames
    repeat (21000) @(posedge clk);
    #3 rst_n = 1'b0;
    $display("txn: reset asserted after long run");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    $display("txn: reset released");

    // Mid-line reset when hcount=500 on the first line
    repeat (501) @(posedge clk);
    #3 rst_n = 1'b0;
    $display("txn: mid-line reset at hcount 500");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    $display("txn: reset released");

    for (int i = 0; i < 6; i++) begin
      run_len  = $urandom_range(20, 2500);
      hold_len = $urandom_range(1, 4);
      repeat (run_len) @(posedge clk);
      #3 rst_n = 1'b0;
      repeat (hold_len) @(posedge clk);
      #3 rst_n = 1'b1;
      $display("txn: random reset after %0d clocks, held %0d clocks", run_len, hold_len);
    end

    repeat (200) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
